// File: rtl/uart8_pkg.sv
// rtl/uart8_pkg.sv - shared types and constants for the uart8 tx arbiter
package uart8_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam int GRANT_W            = 3;

    function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] idx, input int n);
        return (int'(idx) >= n - 1) ? '0 : idx + 1'b1;
    endfunction
endpackage

// File: rtl/uart8_tx_arbiter_if.sv
// rtl/uart8_tx_arbiter_if.sv - requester and Uart8 tx signal bundle for the arbiter
interface uart8_tx_arbiter_if
    import uart8_pkg::*;
#(
    parameter int NUM_REQ = 4
) ();
    logic                   en;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_REQ-1:0]     reqLast;
    logic [8*NUM_REQ-1:0]   reqByte;
    logic [NUM_REQ-1:0]     ack;
    logic [NUM_REQ-1:0]     done;
    logic [GRANT_W-1:0]     grantId;
    logic                   timeoutErr;
    logic                   txEn;
    logic                   txStart;
    logic [7:0]             txIn;
    logic                   txBusy;
    logic                   txDone;

    modport master (
        input  en, req, reqLast, reqByte, txBusy, txDone,
        output ack, done, grantId, timeoutErr, txEn, txStart, txIn
    );

    modport slave (
        output en, req, reqLast, reqByte, txBusy, txDone,
        input  ack, done, grantId, timeoutErr, txEn, txStart, txIn
    );
endinterface

// File: rtl/uart8_rr_pick.sv
// rtl/uart8_rr_pick.sv - combinational round-robin picker, first request at or after ptr
module uart8_rr_pick
    import uart8_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               any,
    output logic [GRANT_W-1:0] winner
);
    logic [NUM_REQ-1:0] rot;
    int                 off;
    int                 sum;

    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    always_comb begin
        rot = NUM_REQ'({req, req} >> ptr);
        off = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = i;
        end
        sum = int'(ptr) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        any    = |req;
        winner = GRANT_W'(sum);
    end
endmodule

// File: rtl/uart8_tx_arbiter.sv
// rtl/uart8_tx_arbiter.sv - round-robin arbiter with frame lock sharing one Uart8 transmitter
module uart8_tx_arbiter
    import uart8_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int LOCK_ENABLE    = 1
) (
    input logic                clk,
    input logic                rstN,
    uart8_tx_arbiter_if.master bus
);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t             state;
    state_t             state_nxt;
    logic [GRANT_W-1:0] ptr;
    logic [GRANT_W-1:0] rr_winner;
    logic [GRANT_W-1:0] winner;
    logic [GRANT_W-1:0] next_ptr;
    logic               rr_any;
    logic               pick_any;
    logic               lock;
    logic               lock_hit;
    logic               last_flag;
    logic               done_prev;
    logic               done_rise;
    logic               tmo_hit;
    logic [NUM_REQ-1:0] grant_oh;
    logic [CNT_W-1:0]   tmo_cnt;
    logic [7:0]         win_byte;

    uart8_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req    (bus.req),
        .ptr    (ptr),
        .any    (rr_any),
        .winner (rr_winner)
    );

    assign grant_oh  = NUM_REQ'(1) << bus.grantId;
    assign lock_hit  = lock && |(bus.req & grant_oh);
    assign pick_any  = lock_hit || rr_any;
    assign winner    = lock_hit ? bus.grantId : rr_winner;
    assign win_byte  = 8'(bus.reqByte >> {winner, 3'b000});
    assign next_ptr  = wrap_inc(bus.grantId, NUM_REQ);
    assign done_rise = bus.txDone && !done_prev;
    assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!bus.en) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (bus.txEn && pick_any) state_nxt = ST_START;
                ST_START: begin
                    if (bus.txBusy)   state_nxt = ST_SEND;
                    else if (tmo_hit) state_nxt = ST_IDLE;
                end
                ST_SEND:  if (done_rise) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // txStart is confined to START so the Uart8 never sees a held start and re-sends.
    always_comb begin
        bus.txStart = (state == ST_START);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bus.ack        <= '0;
            bus.done       <= '0;
            bus.grantId    <= '0;
            bus.timeoutErr <= 1'b0;
            bus.txEn       <= 1'b0;
            bus.txIn       <= '0;
            ptr            <= '0;
            lock           <= 1'b0;
            last_flag      <= 1'b0;
            done_prev      <= 1'b0;
            tmo_cnt        <= '0;
        end else begin
            bus.txEn  <= bus.en;
            done_prev <= bus.txDone;
            bus.ack   <= '0;
            bus.done  <= '0;
            if (!bus.en) begin
                lock           <= 1'b0;
                bus.timeoutErr <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (lock && !lock_hit) lock <= 1'b0;
                        if (bus.txEn && pick_any) begin
                            bus.grantId <= winner;
                            bus.txIn    <= win_byte;
                            tmo_cnt     <= '0;
                        end
                    end
                    ST_START: begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (bus.txBusy) begin
                            bus.ack   <= grant_oh;
                            last_flag <= |(bus.reqLast & grant_oh);
                        end else if (tmo_hit) begin
                            bus.timeoutErr <= 1'b1;
                            ptr            <= next_ptr;
                            lock           <= 1'b0;
                        end
                    end
                    ST_SEND: begin
                        if (done_rise) begin
                            bus.done <= grant_oh;
                            // Pointer stays put while a locked frame is still open.
                            if ((LOCK_ENABLE != 0) && !last_flag) begin
                                lock <= 1'b1;
                            end else begin
                                lock <= 1'b0;
                                ptr  <= next_ptr;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart8_tx_arbiter.sv
// tb/tb_uart8_tx_arbiter.sv - scoreboard bench for uart8_tx_arbiter with a Uart8 tx stand-in
module tb_uart8_tx_arbiter;
    import uart8_pkg::*;

    localparam int N     = 4;
    localparam int FRAME = 10;

    logic clk  = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    uart8_tx_arbiter_if #(.NUM_REQ(N)) bus ();

    uart8_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16), .LOCK_ENABLE(1)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    int         ack_q[$];
    int         done_q[$];
    logic [7:0] frame_q[$];

    logic       stub_en;
    int         busy_cnt;
    logic       cap_v;
    logic [7:0] cap_byte;
    int         mon_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Uart8 tx stand-in: takes txIn on txStart, busy for FRAME cycles, pulses txDone, aborts on txEn low.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            bus.txBusy <= 1'b0;
            bus.txDone <= 1'b0;
            busy_cnt   <= 0;
            cap_v      <= 1'b0;
            cap_byte   <= 8'h00;
        end else begin
            bus.txDone <= 1'b0;
            cap_v      <= 1'b0;
            if (!bus.txEn) begin
                busy_cnt   <= 0;
                bus.txBusy <= 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    bus.txBusy <= 1'b0;
                    bus.txDone <= 1'b1;
                end
            end else if (bus.txStart && stub_en) begin
                bus.txBusy <= 1'b1;
                busy_cnt   <= FRAME;
                cap_v      <= 1'b1;
                cap_byte   <= bus.txIn;
            end
        end
    end

    always @(negedge clk) begin
        if (rstN) begin
            if (bus.ack != '0 || bus.done != '0)
                check("ack_done_excl", 32'((bus.ack != '0) && (bus.done != '0)), 32'd0);
            if (bus.ack != '0) begin
                if (ack_q.size() == 0) check("ack_unexpected", 32'(bus.ack), 32'd0);
                else begin
                    mon_id = ack_q.pop_front();
                    check("ack_vec", 32'(bus.ack), 32'd1 << mon_id);
                    check("ack_grantId", 32'(bus.grantId), 32'(mon_id));
                end
            end
            if (bus.done != '0) begin
                if (done_q.size() == 0) check("done_unexpected", 32'(bus.done), 32'd0);
                else begin
                    mon_id = done_q.pop_front();
                    check("done_vec", 32'(bus.done), 32'd1 << mon_id);
                end
            end
            if (cap_v) begin
                if (frame_q.size() == 0) check("frame_unexpected", 32'(cap_byte), 32'h100);
                else check("frame_byte", 32'(cap_byte), 32'(frame_q.pop_front()));
            end
        end
    end

    task automatic set_req(input int i, input logic [7:0] b, input logic last);
        bus.reqByte[8*i +: 8] = b;
        bus.reqLast[i]        = last;
        bus.req[i]            = 1'b1;
    endtask

    task automatic expect_byte(input int i, input logic [7:0] b, input bit with_done);
        ack_q.push_back(i);
        frame_q.push_back(b);
        if (with_done) done_q.push_back(i);
    endtask

    task automatic wait_ack(output int id, output int ts);
        id = -1;
        ts = 0;
        for (int c = 0; c < 200 && id < 0; c++) begin
            @(negedge clk);
            if (bus.txStart) ts++;
            for (int k = 0; k < N; k++) if (bus.ack[k]) id = k;
        end
        if (id < 0) check("ack_timeout", 32'(bus.ack), 32'hF);
    endtask

    task automatic drain();
        int c = 0;
        while ((ack_q.size() + done_q.size() + frame_q.size()) != 0 && c < 400) begin
            @(negedge clk);
            c++;
        end
        check("drain", 32'(ack_q.size() + done_q.size() + frame_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int id;
        int ts;
        bus.en      = 1'b0;
        bus.req     = '0;
        bus.reqLast = '0;
        bus.reqByte = '0;
        stub_en     = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_grantId", 32'(bus.grantId), 32'd0);
        check("rst_timeoutErr", 32'(bus.timeoutErr), 32'd0);
        check("rst_txEn", 32'(bus.txEn), 32'd0);
        check("rst_txStart", 32'(bus.txStart), 32'd0);
        check("rst_txIn", 32'(bus.txIn), 32'd0);
        rstN   = 1'b1;
        bus.en = 1'b1;
        repeat (3) @(negedge clk);
        check("txEn_follows_en", 32'(bus.txEn), 32'd1);

        // Round-robin from pointer 0.
        for (int i = 0; i < N; i++) begin
            set_req(i, 8'hA0 + 8'(i), 1'b1);
            expect_byte(i, 8'hA0 + 8'(i), 1'b1);
        end
        repeat (N) begin
            wait_ack(id, ts);
            if (id >= 0) bus.req[id] = 1'b0;
        end
        drain();

        // Single requester: one-cycle latency and txStart only during START.
        set_req(0, 8'h7A, 1'b1);
        expect_byte(0, 8'h7A, 1'b1);
        @(negedge clk);
        check("latency_txStart", 32'(bus.txStart), 32'd1);
        check("single_txIn", 32'(bus.txIn), 32'h7A);
        wait_ack(id, ts);
        bus.req[0] = 1'b0;
        check("txStart_cycles", 32'(ts + 1), 32'd2);
        drain();
        check("txStart_idle", 32'(bus.txStart), 32'd0);

        // Locked frame from requester 1 while requester 2 waits.
        set_req(1, 8'h31, 1'b0);
        set_req(2, 8'h55, 1'b1);
        expect_byte(1, 8'h31, 1'b1);
        expect_byte(1, 8'h32, 1'b1);
        expect_byte(1, 8'hB1, 1'b1);
        expect_byte(2, 8'h55, 1'b1);
        wait_ack(id, ts);
        bus.reqByte[15:8] = 8'h32;
        wait_ack(id, ts);
        bus.reqByte[15:8] = 8'hB1;
        bus.reqLast[1]    = 1'b1;
        wait_ack(id, ts);
        bus.req[1] = 1'b0;
        wait_ack(id, ts);
        bus.req[2] = 1'b0;
        drain();

        // Pointer is 3 with req=0101: wrap-around picks 0 first.
        set_req(0, 8'h40, 1'b1);
        set_req(2, 8'h42, 1'b1);
        expect_byte(0, 8'h40, 1'b1);
        expect_byte(2, 8'h42, 1'b1);
        repeat (2) begin
            wait_ack(id, ts);
            if (id >= 0) bus.req[id] = 1'b0;
        end
        drain();

        // Move the pointer to 2, then round-robin again.
        set_req(1, 8'h11, 1'b1);
        expect_byte(1, 8'h11, 1'b1);
        wait_ack(id, ts);
        bus.req[1] = 1'b0;
        drain();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (k + 2) % N;
            set_req(i, 8'hA0 + 8'(i), 1'b1);
            expect_byte(i, 8'hA0 + 8'(i), 1'b1);
        end
        repeat (N) begin
            wait_ack(id, ts);
            if (id >= 0) bus.req[id] = 1'b0;
        end
        drain();

        // Timeout with txBusy never rising.
        stub_en = 1'b0;
        set_req(3, 8'h99, 1'b1);
        ts = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.timeoutErr) break;
            if (bus.txStart) ts++;
        end
        bus.req[3] = 1'b0;
        check("timeout_set", 32'(bus.timeoutErr), 32'd1);
        check("timeout_start_cycles", 32'(ts), 32'd16);
        check("timeout_txStart", 32'(bus.txStart), 32'd0);
        @(negedge clk);
        check("timeout_sticky", 32'(bus.timeoutErr), 32'd1);
        bus.en = 1'b0;
        @(negedge clk);
        check("timeout_clear", 32'(bus.timeoutErr), 32'd0);
        bus.en  = 1'b1;
        stub_en = 1'b1;
        repeat (2) @(negedge clk);

        // Abort mid-SEND: no done, then a clean byte after re-enable.
        set_req(1, 8'hB1, 1'b1);
        ack_q.push_back(1);
        frame_q.push_back(8'hB1);
        wait_ack(id, ts);
        bus.req[1] = 1'b0;
        repeat (3) @(negedge clk);
        bus.en = 1'b0;
        @(negedge clk);
        check("abort_txStart", 32'(bus.txStart), 32'd0);
        repeat (FRAME + 4) @(negedge clk);
        bus.en = 1'b1;
        set_req(3, 8'h0F, 1'b1);
        expect_byte(3, 8'h0F, 1'b1);
        wait_ack(id, ts);
        bus.req[3] = 1'b0;
        drain();

        // Asynchronous reset during START.
        stub_en = 1'b0;
        set_req(2, 8'h5A, 1'b1);
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.txStart) break;
        end
        check("pre_rst_txStart", 32'(bus.txStart), 32'd1);
        check("pre_rst_grantId", 32'(bus.grantId), 32'd2);
        check("pre_rst_txIn", 32'(bus.txIn), 32'h5A);
        #2 rstN = 1'b0;
        #1;
        check("arst_txStart", 32'(bus.txStart), 32'd0);
        check("arst_txIn", 32'(bus.txIn), 32'd0);
        check("arst_grantId", 32'(bus.grantId), 32'd0);
        check("arst_txEn", 32'(bus.txEn), 32'd0);
        check("arst_ack_done", 32'({bus.ack, bus.done}), 32'd0);
        check("arst_timeoutErr", 32'(bus.timeoutErr), 32'd0);
        bus.req = '0;
        @(negedge clk);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        check("end_queues", 32'(ack_q.size() + done_q.size() + frame_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
